// File: rtl/uart_pkg.sv
// Shared types and limits for the parametrised UART receiver.
package uart_pkg;

   localparam int unsigned MinDataBits      = 5;
   localparam int unsigned MaxDataBitsLimit = 9;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_e;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef struct packed {
      logic [3:0] data_bits;
      parity_e    parity;
      logic       two_stop;
   } rx_cfg_t;

   // Frame configuration as captured at start-bit detection, with width clamped.
   function automatic rx_cfg_t latch_cfg(input logic [3:0] bits, input logic [1:0] par,
                                         input logic two_stop, input logic [3:0] max_bits);
      rx_cfg_t c;
      c.data_bits = bits;
      if (bits < 4'(MinDataBits))
         c.data_bits = 4'(MinDataBits);
      else if (bits > max_bits)
         c.data_bits = max_bits;
      case (par)
         2'd1:    c.parity = PAR_EVEN;
         2'd2:    c.parity = PAR_ODD;
         default: c.parity = PAR_NONE;
      endcase
      c.two_stop = two_stop;
      return c;
   endfunction

endpackage

// File: rtl/uart_rx_param_edge_sync.sv
// Two-flop line synchroniser with edge flags qualified by the oversample tick.
module EdgeSyncEn #(
   parameter int unsigned Phase = 1
) (
   input  logic clk,
   input  logic nReset,
   input  logic en,
   input  logic in,
   output logic syncOut,
   output logic rise,
   output logic fall
);

   logic meta_q, sync_q, prev_q;
   logic rise_c, fall_c;

   // Reset to idle-high so reset release never looks like a falling edge.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= in;
         sync_q <= meta_q;
         if (en)
            prev_q <= sync_q;
      end
   end

   assign rise_c = en & sync_q & ~prev_q;
   assign fall_c = en & ~sync_q & prev_q;

   // Phase 1 reports edges alongside syncOut; phase 0 delays everything one clk.
   if (Phase == 1) begin : g_phase1
      assign syncOut = sync_q;
      assign rise    = rise_c;
      assign fall    = fall_c;
   end else begin : g_phase0
      logic sync_d_q, rise_q, fall_q;
      always_ff @(posedge clk or negedge nReset) begin
         if (!nReset) begin
            sync_d_q <= 1'b1;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
         end else begin
            sync_d_q <= sync_q;
            rise_q   <= rise_c;
            fall_q   <= fall_c;
         end
      end
      assign syncOut = sync_d_q;
      assign rise    = rise_q;
      assign fall    = fall_q;
   end

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver with runtime data width, parity and stop bits, break detection
// and a ready/valid output that reports dropped frames as overrun.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int unsigned Oversample  = 16,
   parameter int unsigned MaxDataBits = 9
) (
   input  logic                   clk,
   input  logic                   nReset,
   input  logic                   en,
   input  logic                   in,
   input  logic [3:0]             cfgDataBits,
   input  logic [1:0]             cfgParity,
   input  logic                   cfgStopBits,
   output logic [MaxDataBits-1:0] data,
   output logic                   valid,
   input  logic                   ready,
   output logic                   parityErr,
   output logic                   frameErr,
   output logic                   breakDet,
   output logic                   overrun
);

   localparam int unsigned     CntW    = $clog2(Oversample);
   localparam logic [CntW-1:0] CntFull = CntW'(Oversample - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(Oversample / 2);
   localparam logic [3:0]      MaxBits = 4'(MaxDataBits);

   logic sync_c, rise_c, fall_c;

   EdgeSyncEn #(.Phase(1)) u_sync (
      .clk    (clk),
      .nReset (nReset),
      .en     (en),
      .in     (in),
      .syncOut(sync_c),
      .rise   (rise_c),
      .fall   (fall_c)
   );

   rx_state_e              state_q;
   rx_cfg_t                cfg_q;
   logic [CntW-1:0]        cnt_q;
   logic [3:0]             bit_q;
   logic                   stop_idx_q;
   logic [MaxDataBits-1:0] shreg_q;
   logic                   pbit_q, zero_q, ferr_q;
   logic [MaxDataBits-1:0] data_q;
   logic                   valid_q, perr_q, fe_q, brk_q, ovr_q;

   logic                   mid_c, resync_c, bit_end_c, perr_c, ferr_c;
   logic                   stop_mid_c, break_c, complete_c;
   logic [3:0]             shift_c;
   logic [MaxDataBits-1:0] aligned_c;

   assign mid_c     = (cnt_q == CntHalf);
   assign resync_c  = (state_q inside {START, DATA, PARITY}) && (rise_c || fall_c) && (cnt_q < CntHalf);
   assign bit_end_c = (cnt_q == '0) || resync_c;

   // Bits shift in from the top, so a short word is right-aligned by shifting down.
   assign shift_c   = MaxBits - cfg_q.data_bits;
   assign aligned_c = shreg_q >> shift_c;
   assign perr_c    = (cfg_q.parity != PAR_NONE) &&
                      ((^aligned_c ^ pbit_q) != (cfg_q.parity == PAR_ODD));
   assign ferr_c    = ferr_q | ~sync_c;

   assign stop_mid_c = en && (state_q == STOP) && mid_c;
   assign break_c    = stop_mid_c && !stop_idx_q && zero_q && !sync_c;
   assign complete_c = stop_mid_c && (stop_idx_q == cfg_q.two_stop) && !break_c;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q    <= IDLE;
         cfg_q      <= '0;
         cnt_q      <= CntFull;
         bit_q      <= '0;
         stop_idx_q <= 1'b0;
         shreg_q    <= '0;
         pbit_q     <= 1'b0;
         zero_q     <= 1'b0;
         ferr_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         fe_q       <= 1'b0;
         brk_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         brk_q <= 1'b0;
         ovr_q <= 1'b0;
         if (valid_q && ready)
            valid_q <= 1'b0;

         // A completing frame only loads when the output slot is free or being freed.
         if (complete_c) begin
            if (!valid_q || ready) begin
               data_q  <= aligned_c;
               perr_q  <= perr_c;
               fe_q    <= ferr_c;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end
         if (break_c)
            brk_q <= 1'b1;

         if (en) begin
            case (state_q)
               IDLE: begin
                  if (fall_c) begin
                     state_q    <= START;
                     cnt_q      <= CntFull;
                     cfg_q      <= latch_cfg(cfgDataBits, cfgParity, cfgStopBits, MaxBits);
                     bit_q      <= '0;
                     stop_idx_q <= 1'b0;
                     shreg_q    <= '0;
                     pbit_q     <= 1'b0;
                     zero_q     <= 1'b1;
                     ferr_q     <= 1'b0;
                  end
               end
               START: begin
                  if (mid_c && sync_c) begin
                     state_q <= IDLE;
                     cnt_q   <= CntFull;
                  end else if (bit_end_c) begin
                     state_q <= DATA;
                     cnt_q   <= CntFull;
                  end else begin
                     cnt_q <= cnt_q - CntW'(1);
                  end
               end
               DATA: begin
                  if (mid_c) begin
                     shreg_q <= {sync_c, shreg_q[MaxDataBits-1:1]};
                     zero_q  <= zero_q & ~sync_c;
                     bit_q   <= bit_q + 4'd1;
                     cnt_q   <= cnt_q - CntW'(1);
                  end else if (bit_end_c) begin
                     cnt_q <= CntFull;
                     if (bit_q == cfg_q.data_bits)
                        state_q <= (cfg_q.parity != PAR_NONE) ? PARITY : STOP;
                  end else begin
                     cnt_q <= cnt_q - CntW'(1);
                  end
               end
               PARITY: begin
                  if (mid_c) begin
                     pbit_q <= sync_c;
                     zero_q <= zero_q & ~sync_c;
                     cnt_q  <= cnt_q - CntW'(1);
                  end else if (bit_end_c) begin
                     state_q <= STOP;
                     cnt_q   <= CntFull;
                  end else begin
                     cnt_q <= cnt_q - CntW'(1);
                  end
               end
               STOP: begin
                  if (break_c) begin
                     state_q <= BREAK;
                     cnt_q   <= CntFull;
                  end else if (complete_c) begin
                     state_q <= IDLE;
                     cnt_q   <= CntFull;
                  end else if (mid_c) begin
                     ferr_q <= ferr_c;
                     cnt_q  <= cnt_q - CntW'(1);
                  end else if (bit_end_c) begin
                     stop_idx_q <= 1'b1;
                     cnt_q      <= CntFull;
                  end else begin
                     cnt_q <= cnt_q - CntW'(1);
                  end
               end
               BREAK: begin
                  if (sync_c)
                     state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= CntFull;
               end
            endcase
         end
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign parityErr = perr_q;
   assign frameErr  = fe_q;
   assign breakDet  = brk_q;
   assign overrun   = ovr_q;

endmodule
